// File: rtl/config_frame_loader_pkg.sv
// config_pkg: shared types and header field layout for config_frame_loader.
// Contents: state enum, header field bit positions, desync column code, default sync word.
// Optional feature macro: CONFIG_FRAME_CRC_EN adds the CHECK state.
package config_pkg;
`ifdef CONFIG_FRAME_CRC_EN
  typedef enum logic [1:0] {IDLE, HEADER, DATA, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`endif
  localparam int COL_MSB = 31;
  localparam int COL_LSB = 24;
  localparam int FRAME_MSB = 23;
  localparam int FRAME_LSB = 16;
  localparam int COUNT_MSB = 15;
  localparam int COUNT_LSB = 0;
  localparam logic [7:0] DESYNC_COL = 8'hFF;
  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;
endpackage

// File: rtl/config_frame_loader_if.sv
// config_frame_loader_if: bitstream word input plus frame outputs of the loader.
// master: host side (drives WriteData/WriteStrobe); slave: loader side (drives frame outputs).
interface config_frame_loader_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns = 16
);
  logic [FrameBitsPerRow-1:0] WriteData;
  logic WriteStrobe;
  logic [FrameBitsPerRow-1:0] FrameData;
  logic [NumColumns-1:0] ColSelect;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic ConfigDone;
  logic Error;
  modport master (output WriteData, WriteStrobe, input FrameData, ColSelect, FrameStrobe, ConfigDone, Error);
  modport slave (input WriteData, WriteStrobe, output FrameData, ColSelect, FrameStrobe, ConfigDone, Error);
endinterface

// File: rtl/config_frame_loader_frame_strobe_gen.sv
// frame_strobe_gen: registered one-hot, single-cycle frame strobe.
// Ports: CLK, resetn (async active-low), fire_i request, idx_i frame index, strobe_o one-hot pulse.
module frame_strobe_gen #(
  parameter int MaxFramesPerCol = 20,
  parameter int IdxW = 5
) (
  input  logic CLK,
  input  logic resetn,
  input  logic fire_i,
  input  logic [IdxW-1:0] idx_i,
  output logic [MaxFramesPerCol-1:0] strobe_o
);
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) strobe_o <= '0;
    else strobe_o <= fire_i ? MaxFramesPerCol'(1) << idx_i : '0;
endmodule

// File: rtl/config_frame_loader.sv
// config_frame_loader: sync lock, header decode and frame/column strobe generation.
// Ports: CLK, resetn (async active-low), bus (slave modport: WriteData/WriteStrobe in,
// FrameData/ColSelect/FrameStrobe/ConfigDone/Error out). Macro CONFIG_FRAME_CRC_EN
// enables the per-block XOR check word.
module config_frame_loader
  import config_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns = 16,
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input logic CLK,
  input logic resetn,
  config_frame_loader_if.slave bus
);
  localparam int PtrW = $clog2(MaxFramesPerCol);
  state_t state_q;
  logic [FrameBitsPerRow-1:0] frame_data_q;
  logic [NumColumns-1:0] col_sel_q;
  logic done_q, err_q, fire_q;
  logic [PtrW-1:0] ptr_q, idx_q;
  logic [15:0] rem_q;
  logic [MaxFramesPerCol-1:0] strobe;
`ifdef CONFIG_FRAME_CRC_EN
  logic [FrameBitsPerRow-1:0] crc_q;
`endif
  logic [7:0] col, frm;
  logic [15:0] cnt;
  logic hdr_bad;
  assign col = bus.WriteData[COL_MSB:COL_LSB];
  assign frm = bus.WriteData[FRAME_MSB:FRAME_LSB];
  assign cnt = bus.WriteData[COUNT_MSB:COUNT_LSB];
  assign hdr_bad = col >= 8'(NumColumns) || cnt == 16'd0 || 17'(frm) + 17'(cnt) > 17'(MaxFramesPerCol);
  always_ff @(posedge CLK or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      frame_data_q <= '0;
      col_sel_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      fire_q <= 1'b0;
      ptr_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
`ifdef CONFIG_FRAME_CRC_EN
      crc_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      fire_q <= 1'b0;
      // column stays selected until the last requested strobe has been issued
      if (state_q != DATA && !fire_q) col_sel_q <= '0;
      if (bus.WriteStrobe)
        case (state_q)
          IDLE:
            if (bus.WriteData == SYNC_WORD) begin
              state_q <= HEADER;
              err_q <= 1'b0;
            end
          HEADER:
            if (col == DESYNC_COL) begin
              done_q <= 1'b1;
              state_q <= IDLE;
            end else if (hdr_bad) begin
              err_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              col_sel_q <= NumColumns'(1) << col;
              ptr_q <= PtrW'(frm);
              rem_q <= cnt;
`ifdef CONFIG_FRAME_CRC_EN
              crc_q <= '0;
`endif
              state_q <= DATA;
            end
          DATA: begin
            frame_data_q <= bus.WriteData;
            fire_q <= 1'b1;
            idx_q <= ptr_q;
            ptr_q <= ptr_q + 1'b1;
            rem_q <= rem_q - 16'd1;
`ifdef CONFIG_FRAME_CRC_EN
            crc_q <= crc_q ^ bus.WriteData;
            if (rem_q == 16'd1) state_q <= CHECK;
`else
            if (rem_q == 16'd1) state_q <= HEADER;
`endif
          end
`ifdef CONFIG_FRAME_CRC_EN
          CHECK: begin
            state_q <= bus.WriteData == crc_q ? HEADER : IDLE;
            if (bus.WriteData != crc_q) err_q <= 1'b1;
          end
`endif
          default: state_q <= IDLE;
        endcase
    end
  frame_strobe_gen #(.MaxFramesPerCol(MaxFramesPerCol), .IdxW(PtrW)) u_strobe (
    .CLK(CLK),
    .resetn(resetn),
    .fire_i(fire_q),
    .idx_i(idx_q),
    .strobe_o(strobe)
  );
  assign bus.FrameData = frame_data_q;
  assign bus.ColSelect = col_sel_q;
  assign bus.FrameStrobe = strobe;
  assign bus.ConfigDone = done_q;
  assign bus.Error = err_q;
endmodule
